// File: rtl/adder_result_streamer.sv
// Adder result reporter: captures one DUT sum plus its reference value per handshake,
// keeps saturating pass/fail counts and streams an ANSI-colourised status line
// ("ESC[<code>m" + PASS/FAIL + space + hex sum + "ESC[0m" + LF) one byte per handshake.
module adder_result_streamer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH:0]   in_expected,
    input  logic             in_colour_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    // Number of hex digits needed for the sum including carry-out.
    localparam int unsigned NDig = (WIDTH + 4) / 4;
    localparam int unsigned IdxW = 8;

    localparam logic [IdxW-1:0] LastFixed = IdxW'(4);
    localparam logic [IdxW-1:0] LastDigit = IdxW'(NDig - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OPEN   = 3'd1;
    localparam logic [2:0] ST_TAG    = 3'd2;
    localparam logic [2:0] ST_DIGITS = 3'd3;
    localparam logic [2:0] ST_CLOSE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             match_q, match_d;
    logic             colour_en_q, colour_en_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;

    logic [IdxW-1:0]  last_idx;
    logic [2:0]       next_seg;
    logic             fire;

    logic [7:0]           code_hi, code_lo;
    logic [4*NDig-1:0]    sum_pad;
    logic [4*NDig-1:0]    sum_shift;
    logic [IdxW-1:0]      digit_sel;
    logic [3:0]           nib;
    logic [7:0]           hex_char;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q != ST_IDLE);
    assign fire       = out_valid && out_ready;
    assign pass_count = pass_q;
    assign fail_count = fail_q;

    // Length of the current segment and the segment that follows it.
    always_comb begin
        last_idx = LastFixed;
        next_seg = ST_IDLE;
        case (state_q)
            ST_OPEN:   next_seg = ST_TAG;
            ST_TAG:    next_seg = ST_DIGITS;
            ST_DIGITS: begin
                last_idx = LastDigit;
                next_seg = ST_CLOSE;
            end
            ST_CLOSE:  next_seg = ST_IDLE;
            default:   next_seg = ST_IDLE;
        endcase
    end

    // Next-state: capture in IDLE, otherwise step through the byte sequence on handshakes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        match_d     = match_q;
        colour_en_d = colour_en_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        if (state_q == ST_IDLE) begin
            if (in_valid) begin
                sum_d       = in_sum;
                match_d     = (in_sum == in_expected);
                colour_en_d = in_colour_en;
                state_d     = ST_OPEN;
                idx_d       = '0;
                if (in_sum == in_expected) begin
                    if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                end else begin
                    if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                end
            end
        end else if (fire) begin
            if (idx_q == last_idx) begin
                idx_d   = '0;
                state_d = next_seg;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    // State registers; reset aborts any record in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            match_q     <= 1'b0;
            colour_en_q <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            match_q     <= match_d;
            colour_en_q <= colour_en_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    // Colour code digits: white when colouring is off, yellow for carry-out passes.
    always_comb begin
        code_hi = 8'h33;
        code_lo = 8'h37;
        if (!colour_en_q) begin
            code_hi = 8'h33;
            code_lo = 8'h37;
        end else if (match_q && sum_q[WIDTH]) begin
            code_hi = 8'h33;
            code_lo = 8'h33;
        end else if (match_q) begin
            code_hi = 8'h39;
            code_lo = 8'h34;
        end else begin
            code_hi = 8'h33;
            code_lo = 8'h31;
        end
    end

    // Current hex digit, most significant nibble first, zero-padded.
    always_comb begin
        sum_pad            = '0;
        sum_pad[WIDTH:0]   = sum_q;
        digit_sel          = LastDigit - idx_q;
        sum_shift          = sum_pad >> {digit_sel, 2'b00};
        nib                = sum_shift[3:0];
        hex_char           = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end

    // Output byte mux; 0x00 whenever no record is streaming.
    always_comb begin
        out_data = 8'h00;
        case (state_q)
            ST_OPEN: begin
                case (idx_q)
                    IdxW'(0): out_data = 8'h1B;
                    IdxW'(1): out_data = 8'h5B;
                    IdxW'(2): out_data = code_hi;
                    IdxW'(3): out_data = code_lo;
                    default:  out_data = 8'h6D;
                endcase
            end
            ST_TAG: begin
                case (idx_q)
                    IdxW'(0): out_data = match_q ? 8'h50 : 8'h46;
                    IdxW'(1): out_data = 8'h41;
                    IdxW'(2): out_data = match_q ? 8'h53 : 8'h49;
                    IdxW'(3): out_data = match_q ? 8'h53 : 8'h4C;
                    default:  out_data = 8'h20;
                endcase
            end
            ST_DIGITS: out_data = hex_char;
            ST_CLOSE: begin
                case (idx_q)
                    IdxW'(0): out_data = 8'h1B;
                    IdxW'(1): out_data = 8'h5B;
                    IdxW'(2): out_data = 8'h30;
                    IdxW'(3): out_data = 8'h6D;
                    default:  out_data = 8'h0A;
                endcase
            end
            default: out_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_adder_result_streamer.sv
// Bench for adder_result_streamer: a string-level model of each status line, one
// per-cycle compare process, and directed vectors with literal expectations.
module tb_adder_result_streamer;

    localparam int unsigned W  = 8;
    localparam int unsigned ND = (W + 4) / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W:0]   in_sum = '0;
    logic [W:0]   in_expected = '0;
    logic         in_colour_en = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid;
    logic [7:0]   out_data;
    logic [15:0]  pass_count, fail_count;
    logic         in_ready2, out_valid2;
    logic [7:0]   out_data2;
    logic [1:0]   pass2, fail2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         m_pass = 0;
    int         m_fail = 0;
    bit         bp_en = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    adder_result_streamer #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_expected(in_expected), .in_colour_en(in_colour_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .pass_count(pass_count),
        .fail_count(fail_count)
    );

    adder_result_streamer #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_sum(in_sum),
        .in_expected(in_expected), .in_colour_en(in_colour_en), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .pass_count(pass2),
        .fail_count(fail2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    // The whole status line the sink must receive for one record.
    function automatic void model_record(input logic [W:0] s, input logic [W:0] e,
                                         input logic cen);
        string code, tag, hexs;
        bit    match;
        hexs  = "0123456789ABCDEF";
        match = (s == e);
        if (!cen)                 code = "37";
        else if (match && s[W])   code = "33";
        else if (match)           code = "94";
        else                      code = "31";
        tag = match ? "PASS" : "FAIL";
        exp_q.push_back(8'h1B);
        push_str({"[", code, "m", tag, " "});
        for (int d = ND - 1; d >= 0; d--) exp_q.push_back(hexs[int'((s >> (4 * d)) & 9'hF)]);
        exp_q.push_back(8'h1B);
        push_str("[0m");
        exp_q.push_back(8'h0A);
        if (match) m_pass++;
        else       m_fail++;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        bit idle_now;
        if (rst) begin
            exp_q.delete();
            m_pass  = 0;
            m_fail  = 0;
            stalled = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_pass", 32'(pass_count), 32'd0);
            chk("rst_fail", 32'(fail_count), 32'd0);
        end else begin
            idle_now = (exp_q.size() == 0);
            chk("in_ready", 32'(in_ready), 32'(idle_now));
            chk("out_valid", 32'(out_valid), 32'(!idle_now));
            chk("pass_count", 32'(pass_count), 32'(m_pass));
            chk("fail_count", 32'(fail_count), 32'(m_fail));
            chk("sat_pass", 32'(pass2), 32'(sat3(m_pass)));
            chk("sat_fail", 32'(fail2), 32'(sat3(m_fail)));
            if (out_valid) begin
                if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
                if (stalled) chk("stall_hold", 32'(out_data), 32'(stall_byte));
                if (out_ready) begin
                    got_q.push_back(out_data);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    stall_byte = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && idle_now) model_record(in_sum, in_expected, in_colour_en);
        end
    end

    // Sink backpressure, roughly 30% low when enabled.
    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    // Offer one record; optionally keep in_valid high with junk while the block is busy.
    task automatic send(input logic [W:0] s, input logic [W:0] e, input logic cen,
                        input bit junk);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_sum       = s;
        in_expected  = e;
        in_colour_en = cen;
        @(posedge clk);
        #1;
        if (junk) begin
            in_sum      = ~s;
            in_expected = ~s;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(in_ready && exp_q.size() == 0) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] t1 [18];
        int cyc;
        int guard;
        logic [W:0] s, e;
        t1 = '{8'h1B, 8'h5B, 8'h39, 8'h34, 8'h6D, 8'h50, 8'h41, 8'h53, 8'h53, 8'h20,
               8'h30, 8'h46, 8'h46, 8'h1B, 8'h5B, 8'h30, 8'h6D, 8'h0A};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'h00);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_pass", 32'(pass_count), 32'd0);
        chk("reset_fail", 32'(fail_count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Blue pass line, full literal byte check and turnaround latency.
        got_q.delete();
        send(9'h0FF, 9'h0FF, 1'b1, 1'b0);
        chk("busy_after_capture", 32'(in_ready), 32'd0);
        chk("first_byte", 32'(out_data), 32'h1B);
        cyc = 1;
        while (!in_ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("idle_latency", 32'(cyc), 32'd19);
        wait_idle();
        chk("t1_len", 32'(got_q.size()), 32'd18);
        for (int i = 0; i < 18; i++) chk("t1_byte", 32'(got_q[i]), 32'(t1[i]));
        chk("t1_pass", 32'(pass_count), 32'd1);

        // Yellow pass with carry-out.
        got_q.delete();
        send(9'h1A5, 9'h1A5, 1'b1, 1'b0);
        wait_idle();
        chk("t2_code_hi", 32'(got_q[2]), 32'h33);
        chk("t2_code_lo", 32'(got_q[3]), 32'h33);
        chk("t2_dig0", 32'(got_q[10]), 32'h31);
        chk("t2_dig1", 32'(got_q[11]), 32'h41);
        chk("t2_dig2", 32'(got_q[12]), 32'h35);
        chk("t2_pass", 32'(pass_count), 32'd2);

        // Red fail.
        got_q.delete();
        send(9'h012, 9'h013, 1'b1, 1'b0);
        wait_idle();
        chk("t3_code_hi", 32'(got_q[2]), 32'h33);
        chk("t3_code_lo", 32'(got_q[3]), 32'h31);
        chk("t3_tag0", 32'(got_q[5]), 32'h46);
        chk("t3_tag1", 32'(got_q[6]), 32'h41);
        chk("t3_tag2", 32'(got_q[7]), 32'h49);
        chk("t3_tag3", 32'(got_q[8]), 32'h4C);
        chk("t3_dig", 32'({got_q[10], got_q[11], got_q[12]}), 32'h303132);
        chk("t3_fail", 32'(fail_count), 32'd1);

        // Colour disabled on a mismatch: white, still FAIL.
        got_q.delete();
        send(9'h0AB, 9'h0AC, 1'b0, 1'b0);
        wait_idle();
        chk("t4_code", 32'({got_q[2], got_q[3]}), 32'h3337);
        chk("t4_tag", 32'({got_q[5], got_q[6], got_q[7], got_q[8]}), 32'h4641494C);

        // Backpressure with junk offered while busy; the model checks every byte.
        bp_en = 1'b1;
        for (int r = 0; r < 50; r++) begin
            s = 9'($urandom_range(0, 511));
            e = ($urandom_range(0, 1) == 1) ? s : (s ^ 9'($urandom_range(1, 511)));
            send(s, e, 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle();
        bp_en = 1'b0;

        // Reset after byte 7 aborts the stream and clears the counters.
        got_q.delete();
        send(9'h155, 9'h155, 1'b1, 1'b0);
        guard = 0;
        while (got_q.size() < 7 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("rst_mid_reached", 32'(got_q.size() >= 7), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_now_valid", 32'(out_valid), 32'd0);
        chk("rst_now_pass", 32'(pass_count), 32'd0);
        chk("rst_now_fail", 32'(fail_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        got_q.delete();
        send(9'h0FF, 9'h0FF, 1'b1, 1'b0);
        wait_idle();
        chk("post_rst_len", 32'(got_q.size()), 32'd18);
        chk("post_rst_first", 32'(got_q[0]), 32'h1B);

        // Saturation of the 2-bit instance.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 5; r++) send(9'(r), 9'(r), 1'b1, 1'b0);
        wait_idle();
        chk("sat_pass_lit", 32'(pass2), 32'd3);
        chk("wide_pass_lit", 32'(pass_count), 32'd5);
        send(9'h001, 9'h002, 1'b1, 1'b0);
        send(9'h003, 9'h004, 1'b1, 1'b0);
        wait_idle();
        chk("sat_fail_lit", 32'(fail2), 32'd2);
        chk("sat_pass_hold", 32'(pass2), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_result_streamer.md
# adder_result_streamer

Hardware result reporter for the adder test environment. It accepts one adder result with its expected value per handshake, compares them, and serialises an ANSI-colourised ASCII status line as a byte stream for the console/UART path. The colour scheme matches the testbench text colouriser: ESC "[<code>m", then text, then ESC "[0m". It sits between the DUT/reference-model comparison point and the byte sink, and keeps running pass/fail counts.

## Interface
- WIDTH, 8, adder operand width; sum/expected are WIDTH+1 bits (carry included)
- CNT_W, 16, width of pass/fail counters
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  result record present
- in_ready  output  1  block can accept a record (high only in IDLE)
- in_sum  input  WIDTH+1  DUT sum including carry-out
- in_expected  input  WIDTH+1  reference sum
- in_colour_en  input  1  0 forces white code "37" (escape sequences still emitted)
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts byte
- out_data  output  8  ASCII byte
- pass_count  output  CNT_W  saturating count of matching records
- fail_count  output  CNT_W  saturating count of mismatching records

## Operation
- N = ceil((WIDTH+1)/4) hex digits; record length L = 15+N bytes (18 for WIDTH=8).
- Capture on in_valid && in_ready: register sum, expected, colour_en; match = (sum == expected); increment pass_count or fail_count (saturate at all-ones).
- Colour code: colour_en=0 -> "37"; match && sum[WIDTH]=1 -> "33" (yellow); match otherwise -> "94" (blue); mismatch -> "31" (red).
- Byte sequence: 1B 5B c1 c0 6D; tag "PASS" (50 41 53 53) or "FAIL" (46 41 49 4C); 20; N uppercase hex digits of captured sum, MSB nibble first, zero-padded; 1B 5B 30 6D; 0A.
- FSM: IDLE -> OPEN (5 bytes) -> TAG (5 bytes incl. space) -> DIGITS (N bytes) -> CLOSE (5 bytes incl. newline) -> IDLE. Byte index advances only on out_valid && out_ready.
- in_ready = (state == IDLE). Inputs are ignored outside IDLE.

## Timing
- Reset values: out_valid 0, out_data 0x00, in_ready 1, pass_count 0, fail_count 0, state IDLE.
- out_valid rises the cycle after capture, carrying byte 0 (0x1B).
- With out_ready held high: one byte per cycle. The last byte (0x0A) transfers at cycle L after capture. The FSM is in IDLE with in_ready=1 at cycle L+1. Minimum record period is L+1 cycles.
- While out_valid && !out_ready: out_data and out_valid hold stable; no byte is skipped or repeated.
- out_valid never drops without a handshake during a record. There are no idle bubbles when out_ready is high.
- Counters update the cycle after capture, not at stream end.
- Reset mid-record: the stream aborts immediately, out_valid goes 0, counters clear, and no residual bytes are emitted after reset release.
- A saturated counter stays at all-ones and the other counter still counts.

## Test plan
- WIDTH=8, sum=0x0FF, expected=0x0FF, colour_en=1, out_ready=1 -> 1B 5B 39 34 6D 50 41 53 53 20 30 46 46 1B 5B 30 6D 0A; pass_count=1; in_ready back high 19 cycles after capture.
- sum=0x1A5, expected=0x1A5, colour_en=1 -> code bytes 33 33, digits 31 41 35; pass_count increments.
- sum=0x012, expected=0x013, colour_en=1 -> code bytes 33 31, tag 46 41 49 4C, digits 30 31 32; fail_count=1.
- Mismatch with colour_en=0 -> code bytes 33 37; tag still FAIL.
- Random out_ready backpressure (e.g. 30% low) over 50 records -> byte stream identical to the no-backpressure reference; out_data stable while stalled; in_valid during a stream is not captured.
- Assert rst after byte 7 of a record -> out_valid 0 and counters 0 immediately; the next record after release streams from 0x1B. Separately, CNT_W=2 with 5 passes -> pass_count stays at 3.
